// File: rtl/lfsr_bcd_capture.sv
// Captures one LFSR sample and converts it to packed BCD with
// sequential double-dabble, one bit per clock.
module lfsr_bcd_capture #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      sample_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned BIN_MAX = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned DEC_MAX = pow10(DIGITS) - 64'd1;

  generate
    if (BIN_MAX > DEC_MAX) begin : g_bad_params
      $error("DIGITS too small for WIDTH");
    end
  endgenerate

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    scratch;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    corr;
  logic [BW-1:0]    next_scr;

  // Add-3 on every digit before the shift, digits independent.
  always_comb begin
    corr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        corr[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      else
        corr[4*i +: 4] = scratch[4*i +: 4];
    end
  end

  assign next_scr = {corr[BW-2:0], shreg[WIDTH-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            shreg   <= sample_in;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        (state == SHIFT): begin
          scratch <= next_scr;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_out <= next_scr;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_bcd_capture.sv
// Scoreboard bench for lfsr_bcd_capture: timing model plus
// arithmetic BCD reference, randomized and directed stimulus.
module tb_lfsr_bcd_capture;

  localparam int W = 13;
  localparam int D = 4;

  logic            clk;
  logic            rst;
  logic [W-1:0]    sample_in;
  logic            start;
  logic            busy;
  logic            done;
  logic [4*D-1:0]  bcd_out;

  lfsr_bcd_capture #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_in (sample_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4*D-1:0] val;
    int             due;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  int   cyc;
  int   rem;
  bit   exp_done;
  bit   exp_busy;
  bit   end_req;
  logic [4*D-1:0] last_shown;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference: a start seen while idle yields a result W edges later.
  initial begin
    rem = 0;
    cyc = 0;
    exp_done = 0;
    exp_busy = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        rem = 0;
        exp_done = 0;
        exp_busy = 0;
        q.delete();
      end else begin
        cyc++;
        exp_done = 0;
        if (rem > 0) begin
          rem--;
          if (rem == 0) exp_done = 1;
        end else if (start) begin
          q.push_back('{to_bcd(int'(sample_in)), cyc + W});
          rem = W;
        end
        exp_busy = (rem > 0);
      end
    end
  end

  // Monitor: compares outputs between edges and ends the run.
  initial begin
    exp_t e;
    int   drain;
    checks = 0;
    failures = 0;
    last_shown = '0;
    drain = 0;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd_out), 0);
        last_shown = '0;
      end else begin
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("bcd", 32'(bcd_out), 32'(e.val));
            chk("latency", 32'(cyc), 32'(e.due));
            for (int i = 0; i < D; i++)
              chk("digit_le9", 32'(bcd_out[4*i +: 4] <= 4'd9), 1);
            last_shown = e.val;
          end
        end else begin
          chk("hold", 32'(bcd_out), 32'(last_shown));
        end
        if (end_req) begin
          if (q.size() == 0 && !exp_busy) begin
            $display("TB_RESULT checks=%0d failures=%0d",
                     checks, failures);
            $finish;
          end
          drain++;
          if (drain > 200) begin
            chk("drain_timeout", 1, 0);
            $display("TB_RESULT checks=%0d failures=%0d",
                     checks, failures);
            $finish;
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int v);
    sample_in = W'(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    end_req = 0;
    rst = 1'b0;
    start = 1'b0;
    sample_in = '0;
    #15;
    rst = 1'b1;
    wait_cyc(20);

    pulse(0);
    wait_cyc(15);
    pulse(4096);
    wait_cyc(15);
    pulse(8191);
    wait_cyc(15);

    // start during busy must be ignored
    pulse(1234);
    wait_cyc(4);
    pulse(999);
    wait_cyc(15);

    // back-to-back with start held high
    sample_in = W'(4100);
    start = 1'b1;
    wait_cyc(1);
    sample_in = W'(5000);
    wait_cyc(14);
    sample_in = W'(7777);
    wait_cyc(14);
    start = 1'b0;
    wait_cyc(16);

    // asynchronous reset mid-conversion
    pulse(8000);
    wait_cyc(6);
    #2;
    rst = 1'b0;
    #12;
    rst = 1'b1;
    wait_cyc(1);
    pulse(8000);
    wait_cyc(15);

    // random samples, gaps and in-flight sample changes
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = int'($urandom_range(0, 16));
      for (int g = 0; g < gap; g++) begin
        sample_in = W'($urandom_range(0, 8191));
        start = ($urandom_range(0, 3) == 0);
        wait_cyc(1);
      end
      pulse(int'($urandom_range(0, 8191)));
    end
    start = 1'b0;
    end_req = 1;
  end

endmodule
